// File: rtl/ro_pkg.sv
// Shared definitions for the ring-oscillator TRNG.
//   pair_e   : von Neumann pair-collection state
//   ring_len : delay-LUT count of ring idx, distinct per ring so the rings never lock in phase
package ro_pkg;

  typedef enum logic {
    PAIR_EMPTY = 1'b0,
    PAIR_HALF  = 1'b1
  } pair_e;

  function automatic int unsigned ring_len(input int unsigned base, input int unsigned idx);
    return base + 2 * idx;
  endfunction

endpackage

// File: rtl/ro_trng_ring.sv
// Free-running ring oscillator: one inverter closing a chain of LENGTH buffer stages.
//   osc : raw oscillator output, asynchronous to every clock
module ro_trng_ring #(
  parameter int unsigned LENGTH = 7
) (
  output logic osc
);

  // Every stage kept so synthesis cannot collapse the chain into a single inverter.
  (* keep *) logic [LENGTH:0] node;

  assign node[0] = ~node[LENGTH];

  for (genvar i = 0; i < LENGTH; i++) begin : g_stage
    assign node[i+1] = node[i];
  end

  assign osc = node[0];

endmodule

// File: rtl/ro_trng.sv
// Multi-ring-oscillator TRNG: synchronise the rings, XOR-combine at each sample tick,
// optionally von Neumann debias, pack into words and present them on a valid/ready stream.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : run sampling; low clears the pipeline but keeps the output word
//   ext_src     : substitute ring outputs (USE_EXT_SRC=1 only)
//   data_out    : random word, stable while valid && !ready
//   valid       : data_out holds an unconsumed word
//   ready       : consumer takes the word on valid && ready
//   health_fail : sticky repetition-count alarm
module ro_trng
  import ro_pkg::*;
#(
  parameter int unsigned NUM_RINGS   = 4,
  parameter int unsigned DELAY_LUTS  = 7,
  parameter int unsigned WORD_WIDTH  = 8,
  parameter int unsigned SAMPLE_DIV  = 16,
  parameter bit          DEBIAS      = 1'b1,
  parameter int unsigned REP_LIMIT   = 32,
  parameter bit          USE_EXT_SRC = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NUM_RINGS-1:0]  ext_src,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  valid,
  input  logic                  ready,
  output logic                  health_fail
);

  localparam int unsigned W     = WORD_WIDTH;
  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
  localparam int unsigned CNT_W = $clog2(W + 1);
  localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);

  // Entropy source: the ring bank, or the bench-driven substitute.
  logic [NUM_RINGS-1:0] ring_bits;

  generate
    if (USE_EXT_SRC) begin : g_ext
      assign ring_bits = ext_src;
    end else begin : g_rings
      logic unused_ext;
      assign unused_ext = ^ext_src;
      for (genvar i = 0; i < NUM_RINGS; i++) begin : g_ring
        (* keep *) ro_trng_ring #(
          .LENGTH(ring_len(DELAY_LUTS, i))
        ) u_ring (
          .osc(ring_bits[i])
        );
      end
    end
  endgenerate

  // Two-flop synchronisers, running regardless of enable.
  logic [NUM_RINGS-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ring_bits;
      sync2 <= sync1;
    end
  end

  // Sample tick on the wrap of the divider.
  logic [DIV_W-1:0] div_cnt;
  logic             tick_c;
  logic             raw_c;

  assign tick_c = enable && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign raw_c  = ^sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!enable || tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Repetition-count health test; the tripping bit itself is never emitted.
  logic [REP_W-1:0] rep_cnt, rep_next_c;
  logic             last_raw;
  logic             trip_c, fail_c;

  always_comb begin
    rep_next_c = rep_cnt;
    if (tick_c) begin
      if (rep_cnt == '0 || raw_c != last_raw) begin
        rep_next_c = REP_W'(1);
      end else if (rep_cnt != REP_W'(REP_LIMIT)) begin
        rep_next_c = rep_cnt + REP_W'(1);
      end
    end
  end

  assign trip_c = tick_c && (rep_next_c == REP_W'(REP_LIMIT));
  assign fail_c = health_fail || trip_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt     <= '0;
      last_raw    <= 1'b0;
      health_fail <= 1'b0;
    end else if (!enable) begin
      rep_cnt     <= '0;
      last_raw    <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      rep_cnt <= rep_next_c;
      if (tick_c) begin
        last_raw <= raw_c;
      end
      if (trip_c) begin
        health_fail <= 1'b1;
      end
    end
  end

  // Von Neumann pair FSM: state register.
  pair_e pair_state, pair_next_c;
  logic  pair_bit;
  logic  emit_c, emit_bit_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_state <= PAIR_EMPTY;
    end else begin
      pair_state <= pair_next_c;
    end
  end

  // First bit of the current pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_bit <= 1'b0;
    end else if (tick_c && pair_state == PAIR_EMPTY) begin
      pair_bit <= raw_c;
    end
  end

  // Von Neumann pair FSM: next state and emitted bit.
  always_comb begin
    pair_next_c = pair_state;
    emit_c      = 1'b0;
    emit_bit_c  = raw_c;
    if (!enable || fail_c) begin
      pair_next_c = PAIR_EMPTY;
    end else if (tick_c) begin
      if (!DEBIAS) begin
        emit_c = 1'b1;
      end else begin
        case (pair_state)
          PAIR_EMPTY: pair_next_c = PAIR_HALF;
          PAIR_HALF: begin
            pair_next_c = PAIR_EMPTY;
            emit_c      = (raw_c != pair_bit);
            emit_bit_c  = pair_bit;
          end
          default: pair_next_c = PAIR_EMPTY;
        endcase
      end
    end
  end

  // Word packing and output register. A full accumulator waits for a free output;
  // bits emitted while it waits are dropped.
  logic [W-1:0]     acc;
  logic [CNT_W-1:0] bit_cnt;
  logic             full_c, free_c;
  logic [W-1:0]     shifted_c;

  assign full_c    = (bit_cnt == CNT_W'(W));
  assign free_c    = !valid || ready;
  assign shifted_c = W'({acc, emit_bit_c});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      bit_cnt  <= '0;
      data_out <= '0;
      valid    <= 1'b0;
    end else begin
      if (valid && ready) begin
        valid <= 1'b0;
      end
      if (!enable || fail_c) begin
        acc     <= '0;
        bit_cnt <= '0;
      end else if (full_c) begin
        if (free_c) begin
          data_out <= acc;
          valid    <= 1'b1;
          acc      <= emit_c ? W'(emit_bit_c) : '0;
          bit_cnt  <= emit_c ? CNT_W'(1) : '0;
        end
      end else if (emit_c) begin
        if (bit_cnt == CNT_W'(W - 1) && free_c) begin
          data_out <= shifted_c;
          valid    <= 1'b1;
          acc      <= '0;
          bit_cnt  <= '0;
        end else begin
          acc     <= shifted_c;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ro_trng.sv
// Bench for ro_trng with the ring bank replaced by ext_src.
//   dut_a : raw bits, 8-bit words, repetition limit 16
//   dut_b : von Neumann debiased, 2-bit words, repetition limit 32
// Expected outputs come from a bit-stream model: run lengths, pair rule, word assembly
// with a one-deep output slot plus one waiting word.
module tb_ro_trng;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, rdy_a, en_b, rdy_b;
  logic [3:0] ext_a, ext_b;
  logic [7:0] data_a;
  logic [1:0] data_b;
  logic       valid_a, fail_a, valid_b, fail_b;

  always #5 clk = ~clk;

  ro_trng #(
    .NUM_RINGS(4), .DELAY_LUTS(7), .WORD_WIDTH(8), .SAMPLE_DIV(DIV),
    .DEBIAS(1'b0), .REP_LIMIT(16), .USE_EXT_SRC(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .ext_src(ext_a),
    .data_out(data_a), .valid(valid_a), .ready(rdy_a), .health_fail(fail_a)
  );

  ro_trng #(
    .NUM_RINGS(4), .DELAY_LUTS(7), .WORD_WIDTH(2), .SAMPLE_DIV(DIV),
    .DEBIAS(1'b1), .REP_LIMIT(32), .USE_EXT_SRC(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .ext_src(ext_b),
    .data_out(data_b), .valid(valid_b), .ready(rdy_b), .health_fail(fail_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state, index 0 = dut_a, 1 = dut_b.
  logic [31:0] m_out [2];
  bit          m_occ [2];
  bit          m_held [2];
  logic [31:0] m_held_word [2];
  logic [31:0] m_acc [2];
  int          m_nbits [2];
  int          m_run [2];
  bit          m_last [2];
  bit          m_fail [2];
  bit          m_half [2];
  bit          m_pair [2];

  function automatic void model_clear_pipe(input int which);
    m_acc[which]   = '0;
    m_nbits[which] = 0;
    m_run[which]   = 0;
    m_fail[which]  = 1'b0;
    m_half[which]  = 1'b0;
    m_held[which]  = 1'b0;
  endfunction

  function automatic void model_reset(input int which);
    model_clear_pipe(which);
    m_occ[which] = 1'b0;
    m_out[which] = '0;
  endfunction

  function automatic void model_ready(input int which);
    if (m_occ[which]) begin
      if (m_held[which]) begin
        m_out[which]  = m_held_word[which];
        m_held[which] = 1'b0;
      end else begin
        m_occ[which] = 1'b0;
      end
    end
  endfunction

  function automatic void model_tick(input int which, input bit raw);
    int  w, lim;
    bit  emit, b;
    w   = (which == 1) ? 2 : 8;
    lim = (which == 1) ? 32 : 16;
    if (m_run[which] == 0 || raw != m_last[which]) m_run[which] = 1;
    else if (m_run[which] < lim) m_run[which]++;
    m_last[which] = raw;
    if (m_run[which] == lim) m_fail[which] = 1'b1;
    if (m_fail[which]) begin
      m_acc[which]   = '0;
      m_nbits[which] = 0;
      m_half[which]  = 1'b0;
      m_held[which]  = 1'b0;
      return;
    end
    emit = 1'b0;
    b    = raw;
    if (which == 0) begin
      emit = 1'b1;
    end else if (!m_half[which]) begin
      m_pair[which] = raw;
      m_half[which] = 1'b1;
    end else begin
      m_half[which] = 1'b0;
      emit = (raw != m_pair[which]);
      b    = m_pair[which];
    end
    if (!emit || m_held[which]) return;
    m_acc[which] = m_acc[which] * 2 + 32'(b);
    m_nbits[which]++;
    if (m_nbits[which] == w) begin
      if (!m_occ[which]) begin
        m_out[which] = m_acc[which];
        m_occ[which] = 1'b1;
      end else begin
        m_held[which]      = 1'b1;
        m_held_word[which] = m_acc[which];
      end
      m_acc[which]   = '0;
      m_nbits[which] = 0;
    end
  endfunction

  // One sample period: present a random source vector whose XOR is raw, optionally pulse
  // ready on the first edge, and return at the negedge after the tick edge.
  task automatic drive_tick(input int which, input bit raw, input bit pulse);
    logic [3:0] v;
    bit         rdy_level;
    v = 4'($urandom);
    if ((^v) != raw) v[0] = ~v[0];
    if (which == 0) begin
      ext_a = v;
      if (pulse) rdy_a = 1'b1;
    end else begin
      ext_b = v;
      if (pulse) rdy_b = 1'b1;
    end
    rdy_level = (which == 0) ? rdy_a : rdy_b;
    for (int i = 0; i < int'(DIV); i++) begin
      @(posedge clk);
      if (i == 0 && pulse) begin
        #1;
        if (which == 0) rdy_a = 1'b0;
        else rdy_b = 1'b0;
      end
    end
    @(negedge clk);
    if (rdy_level) model_ready(which);
    model_tick(which, raw);
  endtask

  task automatic test_reset();
    vectors++;
    if (data_a !== 8'h00 || valid_a !== 1'b0 || fail_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_a: got data=%h valid=%b fail=%b, want 00 0 0", data_a, valid_a, fail_a);
    end
    vectors++;
    if (data_b !== 2'b00 || valid_b !== 1'b0 || fail_b !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_b: got data=%b valid=%b fail=%b, want 00 0 0", data_b, valid_b, fail_b);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got valid_a=%b valid_b=%b, want 0 0", valid_a, valid_b);
    end
    model_reset(0);
    model_reset(1);
  endtask

  task automatic test_raw_word();
    bit seq [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    en_a  = 1'b1;
    rdy_a = 1'b1;
    model_clear_pipe(0);
    for (int t = 0; t < 8; t++) begin
      drive_tick(0, seq[t], 1'b0);
      vectors++;
      if (valid_a !== m_occ[0] || data_a !== m_out[0][7:0] || fail_a !== m_fail[0]) begin
        miscompares++;
        $display("FAIL raw_word tick %0d: got valid=%b data=%h fail=%b, want valid=%b data=%h fail=%b",
                 t, valid_a, data_a, fail_a, m_occ[0], m_out[0][7:0], m_fail[0]);
      end
    end
    vectors++;
    if (data_a !== 8'hB2 || valid_a !== 1'b1 || fail_a !== 1'b0) begin
      miscompares++;
      $display("FAIL raw_word_b2: got data=%h valid=%b fail=%b, want b2 1 0", data_a, valid_a, fail_a);
    end
  endtask

  task automatic test_random_raw();
    bit raw, pulse;
    rdy_a = 1'b0;
    for (int t = 0; t < 48; t++) begin
      raw   = 1'($urandom);
      pulse = 1'($urandom);
      drive_tick(0, raw, pulse);
      vectors++;
      if (valid_a !== m_occ[0] || data_a !== m_out[0][7:0] || fail_a !== m_fail[0]) begin
        miscompares++;
        $display("FAIL random_raw tick %0d: got valid=%b data=%h fail=%b, want valid=%b data=%h fail=%b",
                 t, valid_a, data_a, fail_a, m_occ[0], m_out[0][7:0], m_fail[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit         bits [24];
    logic [7:0] w0, w1;
    // Drain the output and restart the pipeline.
    en_a  = 1'b0;
    rdy_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_clear_pipe(0);
    model_ready(0);
    en_a  = 1'b1;
    rdy_a = 1'b0;
    w0 = '0;
    w1 = '0;
    for (int i = 0; i < 24; i++) begin
      bits[i] = 1'($urandom);
      if (i % 10 == 9) bits[i] = ~bits[i-1];
      if (i < 8) w0 = {w0[6:0], bits[i]};
      else if (i < 16) w1 = {w1[6:0], bits[i]};
    end
    for (int t = 0; t < 24; t++) begin
      drive_tick(0, bits[t], 1'b0);
      vectors++;
      if (valid_a !== m_occ[0] || data_a !== m_out[0][7:0] || fail_a !== m_fail[0]) begin
        miscompares++;
        $display("FAIL stall tick %0d: got valid=%b data=%h fail=%b, want valid=%b data=%h fail=%b",
                 t, valid_a, data_a, fail_a, m_occ[0], m_out[0][7:0], m_fail[0]);
      end
    end
    vectors++;
    if (data_a !== w0 || valid_a !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_word0: got data=%h valid=%b, want %h 1", data_a, valid_a, w0);
    end
    drive_tick(0, 1'($urandom), 1'b1);
    vectors++;
    if (data_a !== w1 || valid_a !== 1'b1) begin
      miscompares++;
      $display("FAIL held_word1: got data=%h valid=%b, want %h 1", data_a, valid_a, w1);
    end
    // enable low keeps the unconsumed word but discards the pipeline.
    en_a = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_clear_pipe(0);
    vectors++;
    if (data_a !== w1 || valid_a !== 1'b1 || fail_a !== 1'b0) begin
      miscompares++;
      $display("FAIL disable_keeps_word: got data=%h valid=%b fail=%b, want %h 1 0", data_a, valid_a, fail_a, w1);
    end
    en_a = 1'b1;
    drive_tick(0, 1'($urandom), 1'b1);
    vectors++;
    if (valid_a !== 1'b0 || data_a !== w1 || valid_a !== m_occ[0]) begin
      miscompares++;
      $display("FAIL drain_after_disable: got data=%h valid=%b, want %h 0", data_a, valid_a, w1);
    end
  endtask

  task automatic test_health();
    en_a  = 1'b0;
    rdy_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_clear_pipe(0);
    model_ready(0);
    en_a = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      drive_tick(0, 1'b1, 1'b0);
      vectors++;
      if (valid_a !== m_occ[0] || data_a !== m_out[0][7:0] || fail_a !== m_fail[0]) begin
        miscompares++;
        $display("FAIL health tick %0d: got valid=%b data=%h fail=%b, want valid=%b data=%h fail=%b",
                 t, valid_a, data_a, fail_a, m_occ[0], m_out[0][7:0], m_fail[0]);
      end
      if (t == 8) begin
        vectors++;
        if (data_a !== 8'hFF || valid_a !== 1'b1) begin
          miscompares++;
          $display("FAIL health_first_word: got data=%h valid=%b, want ff 1", data_a, valid_a);
        end
      end
      if (t == 15 || t == 16) begin
        vectors++;
        if (fail_a !== (t == 16)) begin
          miscompares++;
          $display("FAIL health_trip tick %0d: got fail=%b, want %b", t, fail_a, (t == 16));
        end
      end
      if (t > 16) begin
        vectors++;
        if (valid_a !== 1'b0) begin
          miscompares++;
          $display("FAIL health_silent tick %0d: got valid=%b, want 0", t, valid_a);
        end
      end
    end
    en_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_clear_pipe(0);
    vectors++;
    if (fail_a !== 1'b0) begin
      miscompares++;
      $display("FAIL health_clear: got fail=%b, want 0", fail_a);
    end
    en_a = 1'b1;
    for (int t = 0; t < 8; t++) begin
      drive_tick(0, (t % 2 == 0), 1'b0);
    end
    vectors++;
    if (data_a !== 8'hAA || valid_a !== 1'b1 || fail_a !== 1'b0) begin
      miscompares++;
      $display("FAIL health_recover: got data=%h valid=%b fail=%b, want aa 1 0", data_a, valid_a, fail_a);
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] w;
    bit         raw;
    for (int t = 0; t < 5; t++) drive_tick(0, 1'($urandom), 1'b0);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (data_a !== 8'h00 || valid_a !== 1'b0 || fail_a !== 1'b0) begin
      miscompares++;
      $display("FAIL midword_reset: got data=%h valid=%b fail=%b, want 00 0 0", data_a, valid_a, fail_a);
    end
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    rst_n = 1'b1;
    w = '0;
    for (int t = 0; t < 8; t++) begin
      raw = (t == 3) ? 1'b0 : ((t == 4) ? 1'b1 : 1'($urandom));
      w = {w[6:0], raw};
      drive_tick(0, raw, 1'b0);
      vectors++;
      if (valid_a !== m_occ[0] || data_a !== m_out[0][7:0] || fail_a !== m_fail[0]) begin
        miscompares++;
        $display("FAIL post_reset tick %0d: got valid=%b data=%h fail=%b, want valid=%b data=%h fail=%b",
                 t, valid_a, data_a, fail_a, m_occ[0], m_out[0][7:0], m_fail[0]);
      end
    end
    vectors++;
    if (data_a !== w || valid_a !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_word: got data=%h valid=%b, want %h 1", data_a, valid_a, w);
    end
  endtask

  task automatic test_debias();
    bit seq [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
    en_b  = 1'b1;
    rdy_b = 1'b1;
    model_clear_pipe(1);
    for (int t = 0; t < 8; t++) begin
      drive_tick(1, seq[t], 1'b0);
      vectors++;
      if (valid_b !== m_occ[1] || data_b !== m_out[1][1:0] || fail_b !== m_fail[1]) begin
        miscompares++;
        $display("FAIL debias tick %0d: got valid=%b data=%b fail=%b, want valid=%b data=%b fail=%b",
                 t, valid_b, data_b, fail_b, m_occ[1], m_out[1][1:0], m_fail[1]);
      end
      if (t == 5) begin
        vectors++;
        if (data_b !== 2'b01 || valid_b !== 1'b1) begin
          miscompares++;
          $display("FAIL debias_word: got data=%b valid=%b, want 01 1", data_b, valid_b);
        end
      end
    end
    vectors++;
    if (valid_b !== 1'b0) begin
      miscompares++;
      $display("FAIL debias_equal_pairs: got valid=%b, want 0", valid_b);
    end
    rdy_b = 1'b0;
    for (int t = 0; t < 60; t++) begin
      drive_tick(1, 1'($urandom), 1'($urandom));
      vectors++;
      if (valid_b !== m_occ[1] || data_b !== m_out[1][1:0] || fail_b !== m_fail[1]) begin
        miscompares++;
        $display("FAIL debias_random tick %0d: got valid=%b data=%b fail=%b, want valid=%b data=%b fail=%b",
                 t, valid_b, data_b, fail_b, m_occ[1], m_out[1][1:0], m_fail[1]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en_a  = 1'b0;
    rdy_a = 1'b0;
    en_b  = 1'b0;
    rdy_b = 1'b0;
    ext_a = '0;
    ext_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_raw_word();
    test_random_raw();
    test_back_to_back();
    test_health();
    test_reset_midword();
    test_debias();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
